// File: rtl/beaver_run_ctrl.sv
// Run controller for the beaver32rv core: free-run / single-step / halt gating
// through core_en, plus a circular retirement-trace FIFO drained by a host.
module beaver_run_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step,
  input  logic [CW-1:0]            cycle_limit,
  input  logic                     bp_en,
  input  logic [XLEN-1:0]          bp_addr,
  input  logic [XLEN-1:0]          pc_addr,
  input  logic                     reg_write,
  input  logic [4:0]               rd_addr,
  input  logic [XLEN-1:0]          rd_data,
  input  logic                     branch_taken,
  output logic                     core_en,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [CW-1:0]            cycle_count,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [XLEN-1:0]          tr_pc,
  output logic [4:0]               tr_rd,
  output logic [XLEN-1:0]          tr_data,
  output logic                     tr_we,
  output logic                     tr_br,
  output logic [$clog2(DEPTH):0]   tr_count,
  output logic                     tr_overflow,
  output logic [1:0]               fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALT = 2'd3} state_t;

  state_t          state, state_nx;
  logic            bp_skip, bp_skip_nx;
  logic [1:0]      cause, cause_nx;
  logic [CW-1:0]   count, count_nx, count_inc;
  logic            clr_ovf;
  logic            bp_hit;

  assign count_inc = count + CW'(1);
  // bp_skip lets the instruction sitting on the breakpoint execute after a restart.
  assign bp_hit    = bp_en && (pc_addr == bp_addr) && !bp_skip;

  always_comb begin
    state_nx   = state;
    bp_skip_nx = bp_skip;
    cause_nx   = cause;
    count_nx   = count;
    clr_ovf    = 1'b0;
    core_en    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nx   = RUN;
          count_nx   = '0;
          cause_nx   = 2'b00;
          bp_skip_nx = 1'b1;
          clr_ovf    = 1'b1;
        end else if (step) begin
          state_nx = STEP;
        end
      end
      RUN: begin
        if (bp_hit) begin
          state_nx = HALT;
          cause_nx = 2'b10;
        end else begin
          core_en    = 1'b1;
          count_nx   = count_inc;
          bp_skip_nx = 1'b0;
          if ((cycle_limit != '0) && (count_inc == cycle_limit)) begin
            state_nx = HALT;
            cause_nx = 2'b01;
          end
        end
      end
      STEP: begin
        core_en    = 1'b1;
        count_nx   = count_inc;
        bp_skip_nx = 1'b0;
        state_nx   = HALT;
        cause_nx   = 2'b11;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bp_skip <= 1'b0;
      cause   <= 2'b00;
      count   <= '0;
    end else begin
      state   <= state_nx;
      bp_skip <= bp_skip_nx;
      cause   <= cause_nx;
      count   <= count_nx;
    end
  end

  assign halted      = (state == HALT);
  assign halt_cause  = cause;
  assign cycle_count = count;
  assign fsm_state   = state;

  // Trace FIFO: one entry per enabled core cycle; when full and not drained,
  // the oldest entry is overwritten so the newest history is always kept.
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   cnt;
  logic            push, pop, full, drop;
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic            mem_we   [DEPTH];
  logic            mem_br   [DEPTH];

  assign push = core_en;
  assign pop  = tr_valid && tr_ready;
  assign full = (cnt == FULL_CNT);
  assign drop = push && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      tr_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
        mem_we[i]   <= 1'b0;
        mem_br[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= pc_addr;
        mem_rd[wr_ptr]   <= rd_addr;
        mem_data[wr_ptr] <= rd_data;
        mem_we[wr_ptr]   <= reg_write;
        mem_br[wr_ptr]   <= branch_taken;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop || drop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop && !full) cnt <= cnt + NW'(1);
      else if (pop && !push)     cnt <= cnt - NW'(1);
      if (clr_ovf)   tr_overflow <= 1'b0;
      else if (drop) tr_overflow <= 1'b1;
    end
  end

  assign tr_valid = (cnt != '0);
  assign tr_count = cnt;
  assign tr_pc    = mem_pc[rd_ptr];
  assign tr_rd    = mem_rd[rd_ptr];
  assign tr_data  = mem_data[rd_ptr];
  assign tr_we    = mem_we[rd_ptr];
  assign tr_br    = mem_br[rd_ptr];
endmodule

// File: tb/tb_beaver_run_ctrl.sv
// Directed bench for beaver_run_ctrl: a tiny PC-stepping core model drives the
// inputs, and a queue scoreboard tracks the expected trace FIFO contents.
module tb_beaver_run_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int EW    = XLEN + 5 + XLEN + 2;

  logic             clk, rst, start, step, bp_en, reg_write, branch_taken, tr_ready;
  logic [CW-1:0]    cycle_limit;
  logic [XLEN-1:0]  bp_addr, pc_addr, rd_data;
  logic [4:0]       rd_addr;
  logic             core_en, halted, tr_valid, tr_we, tr_br, tr_overflow;
  logic [1:0]       halt_cause, fsm_state;
  logic [CW-1:0]    cycle_count;
  logic [XLEN-1:0]  tr_pc, tr_data;
  logic [4:0]       tr_rd;
  logic [$clog2(DEPTH):0] tr_count;

  beaver_run_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .cycle_limit(cycle_limit),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr), .reg_write(reg_write),
    .rd_addr(rd_addr), .rd_data(rd_data), .branch_taken(branch_taken),
    .core_en(core_en), .halted(halted), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_pc(tr_pc), .tr_rd(tr_rd), .tr_data(tr_data), .tr_we(tr_we), .tr_br(tr_br),
    .tr_count(tr_count), .tr_overflow(tr_overflow), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int drops = 0;
  logic [XLEN-1:0] pc;
  logic [EW-1:0] exp_q[$];
  logic          exp_ovf;
  logic          prev_stall, prev_drop;
  logic [EW-1:0] prev_head;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_core();
    pc_addr      = pc;
    rd_addr      = pc[6:2];
    rd_data      = {pc[15:0], ~pc[15:0]};
    reg_write    = pc[2];
    branch_taken = pc[4];
  endtask

  // One clock: check FIFO state at negedge, update the model, then let the
  // core model retire an instruction if core_en was high.
  task automatic tick();
    logic en, pop, drop, nonempty;
    logic [EW-1:0] head;
    @(negedge clk);
    en       = core_en;
    nonempty = (exp_q.size() != 0);
    head     = {tr_pc, tr_rd, tr_data, tr_we, tr_br};
    chk("tr_valid", EW'(tr_valid), EW'(nonempty));
    chk("tr_count", EW'(tr_count), EW'(exp_q.size()));
    chk("tr_overflow", EW'(tr_overflow), EW'(exp_ovf));
    if (nonempty) chk("tr_head", head, exp_q[0]);
    if (prev_stall && !prev_drop) chk("tr_stable", head, prev_head);
    pop  = nonempty && tr_ready;
    drop = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (en) begin
      if (exp_q.size() == DEPTH) begin
        void'(exp_q.pop_front());
        drop    = 1'b1;
        exp_ovf = 1'b1;
        drops++;
      end
      exp_q.push_back({pc_addr, rd_addr, rd_data, reg_write, branch_taken});
      en_cnt++;
    end
    prev_stall = nonempty && !tr_ready;
    prev_drop  = drop;
    prev_head  = head;
    @(posedge clk);
    #1;
    if (en) begin
      pc = pc + 32'd4;
      drive_core();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start   = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_ovf    = 1'b0;
    prev_stall = 1'b0;
    prev_drop  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_en"}, EW'(core_en), '0);
    chk({tag, "_halted"}, EW'(halted), '0);
    chk({tag, "_cause"}, EW'(halt_cause), '0);
    chk({tag, "_count"}, EW'(cycle_count), '0);
    chk({tag, "_tr_valid"}, EW'(tr_valid), '0);
    chk({tag, "_tr_count"}, EW'(tr_count), '0);
    chk({tag, "_tr_ovf"}, EW'(tr_overflow), '0);
    chk({tag, "_tr_head"}, {tr_pc, tr_rd, tr_data, tr_we, tr_br}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; step = 1'b0; tr_ready = 1'b0;
    pc = '0;
    drive_core();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cycle_limit = '0; bp_en = 1'b0; bp_addr = '0;
    // Limit halt with overflow: 18 retirements into a 16-deep trace
    do_reset();
    cycle_limit = 16'd18;
    en_cnt = 0;
    pulse_start();
    repeat (25) tick();
    chk("lim_en_cycles", EW'(en_cnt), EW'(18));
    chk("lim_halted", EW'(halted), EW'(1));
    chk("lim_cause", EW'(halt_cause), EW'(2'b01));
    chk("lim_count", EW'(cycle_count), EW'(18));
    chk("lim_tr_count", EW'(tr_count), EW'(16));
    chk("lim_ovf", EW'(tr_overflow), EW'(1));
    chk("lim_first_pc", EW'(tr_pc), EW'(32'h8));
    tr_ready = 1'b1;
    repeat (17) tick();
    chk("lim_drained", EW'(tr_count), EW'(0));

    // Breakpoint at 0x10, then restart past it
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10; cycle_limit = '0; tr_ready = 1'b1;
    en_cnt = 0;
    pulse_start();
    repeat (10) tick();
    chk("bp_en_cycles", EW'(en_cnt), EW'(4));
    chk("bp_halted", EW'(halted), EW'(1));
    chk("bp_cause", EW'(halt_cause), EW'(2'b10));
    chk("bp_pc", EW'(pc_addr), EW'(32'h10));
    chk("bp_count", EW'(cycle_count), EW'(4));
    chk("bp_core_en", EW'(core_en), EW'(0));
    cycle_limit = 16'd3;
    en_cnt = 0;
    pulse_start();
    repeat (8) tick();
    chk("bp2_en_cycles", EW'(en_cnt), EW'(3));
    chk("bp2_cause", EW'(halt_cause), EW'(2'b01));
    chk("bp2_pc", EW'(pc_addr), EW'(32'h1c));

    // Three single steps from HALT, four cycles apart
    bp_en = 1'b0;
    tr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en_cnt = 0;
      pulse_step();
      repeat (3) tick();
      chk("step_en_cycles", EW'(en_cnt), EW'(1));
      chk("step_cause", EW'(halt_cause), EW'(2'b11));
      chk("step_halted", EW'(halted), EW'(1));
      chk("step_count", EW'(cycle_count), EW'(4 + i));
    end
    chk("step_tr_count", EW'(tr_count), EW'(3));
    chk("step_pc", EW'(pc_addr), EW'(32'h28));

    // Full FIFO, host draining while four more entries arrive
    do_reset();
    cycle_limit = 16'd20;
    pulse_start();
    repeat (16) tick();
    chk("full_tr_count", EW'(tr_count), EW'(16));
    tr_ready = 1'b1;
    en_cnt = 0;
    repeat (4) tick();
    chk("full_en_cycles", EW'(en_cnt), EW'(4));
    chk("full_halted", EW'(halted), EW'(1));
    chk("full_count", EW'(cycle_count), EW'(20));
    chk("full_tr_count2", EW'(tr_count), EW'(16));
    chk("full_ovf", EW'(tr_overflow), EW'(0));
    chk("full_head_pc", EW'(tr_pc), EW'(32'h10));
    repeat (17) tick();
    chk("full_drained", EW'(tr_count), EW'(0));

    // 40-cycle run with a randomly stalling host
    cycle_limit = 16'd40;
    en_cnt = 0;
    drops = 0;
    pulse_start();
    for (int i = 0; i < 80 && !halted; i++) begin
      tr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rnd_halted", EW'(halted), EW'(1));
    chk("rnd_en_cycles", EW'(en_cnt), EW'(40));
    chk("rnd_count", EW'(cycle_count), EW'(40));
    chk("rnd_ovf", EW'(tr_overflow), EW'(drops != 0));
    tr_ready = 1'b1;
    repeat (18) tick();
    chk("rnd_drained", EW'(tr_count), EW'(0));

    // Reset in the middle of a RUN cycle
    cycle_limit = '0;
    tr_ready = 1'b0;
    pulse_start();
    repeat (5) tick();
    chk("mid_core_en_pre", EW'(core_en), EW'(1));
    chk("mid_state_run", EW'(fsm_state), EW'(2'd1));
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("mid");
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    chk("post_count0", EW'(cycle_count), EW'(0));
    tick();
    chk("post_count1", EW'(cycle_count), EW'(1));
    tick();
    chk("post_count2", EW'(cycle_count), EW'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
